// File: rtl/array_mul_usign.sv
// rtl/array_mul_usign.sv - Unsigned NxM AND/adder-array multiplier with registered operands and product
// Optional macro ARRAY_MUL_PIPE_EN inserts a register stage after row M/2 (latency 3 instead of 2).
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    assign s  = a ^ b;
    assign co = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module array_mul_usign #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   A,
    input  logic [M-1:0]   B,
    output logic [N+M-1:0] Y
);
    localparam int H = M / 2;

    logic [N-1:0]   a_q;
    logic [M-1:0]   b_q;
    logic [N-1:0]   a_row   [M];
    logic [M-1:0]   b_bit;
    logic [N-1:0]   sum_row [M];
    logic [N-1:0]   sum_vis [M];
    logic [M-1:1]   cry_row;
    logic [M-1:1]   cry_vis;
    logic [N+M-1:0] prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            Y   <= '0;
        end else begin
            a_q <= A;
            b_q <= B;
            Y   <= prod;
        end
    end

`ifdef ARRAY_MUL_PIPE_EN
    // Mid-array stage: running sum/carry of row H, finished low bits, and operands for the later rows.
    logic [N-1:0]   a_p;
    logic [M-1:H+1] b_p;
    logic [N-1:0]   sum_p;
    logic           cry_p;
    logic [H-1:0]   lo_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p   <= '0;
            b_p   <= '0;
            sum_p <= '0;
            cry_p <= 1'b0;
            lo_p  <= '0;
        end else begin
            a_p   <= a_q;
            b_p   <= b_q[M-1:H+1];
            sum_p <= sum_row[H];
            cry_p <= cry_row[H];
            for (int k = 0; k < H; k++) lo_p[k] <= sum_row[k][0];
        end
    end
`endif

    for (genvar j = 0; j < M; j++) begin : g_op
`ifdef ARRAY_MUL_PIPE_EN
        if (j > H) begin : g_late
            assign a_row[j] = a_p;
            assign b_bit[j] = b_p[j];
        end else begin : g_early
            assign a_row[j] = a_q;
            assign b_bit[j] = b_q[j];
        end
        if (j == H) begin : g_vis_pipe
            assign sum_vis[j] = sum_p;
            assign cry_vis[j] = cry_p;
        end else begin : g_vis
            assign sum_vis[j] = sum_row[j];
            if (j >= 1) begin : g_cry
                assign cry_vis[j] = cry_row[j];
            end
        end
`else
        assign a_row[j]   = a_q;
        assign b_bit[j]   = b_q[j];
        assign sum_vis[j] = sum_row[j];
        if (j >= 1) begin : g_cry
            assign cry_vis[j] = cry_row[j];
        end
`endif
    end

    assign sum_row[0] = a_row[0] & {N{b_bit[0]}};

    // Row j adds pp[j] to the previous sum shifted right by one; its bit 0 is a finished product bit.
    for (genvar j = 1; j < M; j++) begin : g_row
        logic [N-1:0] pp;
        logic [N-1:0] s;
        logic [N:1]   c;

        assign pp = a_row[j] & {N{b_bit[j]}};

        half_adder u_lsb (.a(pp[0]), .b(sum_vis[j-1][1]), .s(s[0]), .co(c[1]));

        for (genvar i = 1; i < N - 1; i++) begin : g_mid
            full_adder u_fa (.a(pp[i]), .b(sum_vis[j-1][i+1]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
        end

        if (j == 1) begin : g_msb_ha
            half_adder u_msb (.a(pp[N-1]), .b(c[N-1]), .s(s[N-1]), .co(c[N]));
        end else begin : g_msb_fa
            full_adder u_msb (.a(pp[N-1]), .b(cry_vis[j-1]), .ci(c[N-1]), .s(s[N-1]), .co(c[N]));
        end

        assign sum_row[j] = s;
        assign cry_row[j] = c[N];
    end

    for (genvar j = 0; j < M - 1; j++) begin : g_lo
`ifdef ARRAY_MUL_PIPE_EN
        if (j < H) begin : g_reg
            assign prod[j] = lo_p[j];
        end else begin : g_comb
            assign prod[j] = sum_vis[j][0];
        end
`else
        assign prod[j] = sum_vis[j][0];
`endif
    end

    assign prod[N+M-1:M-1] = {cry_vis[M-1], sum_vis[M-1]};

endmodule

// File: tb/tb_array_mul_usign.sv
// tb/tb_array_mul_usign.sv - Self-checking bench for array_mul_usign (honours ARRAY_MUL_PIPE_EN)
module tb_array_mul_usign;
    localparam int N = 8;
    localparam int M = 8;
`ifdef ARRAY_MUL_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   A;
    logic [M-1:0]   B;
    logic [N+M-1:0] Y;

    int n_vec = 0;
    int n_err = 0;
    logic [N+M-1:0] exp_q [$];

    array_mul_usign #(.N(N), .M(M)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .Y    (Y)
    );

    always #5 clk = ~clk;

    function automatic logic [N+M-1:0] ref_mul(input logic [N-1:0] a, input logic [M-1:0] b);
        logic [N+M-1:0] wa;
        logic [N+M-1:0] wb;
        wa = a;
        wb = b;
        return wa * wb;
    endfunction

    task automatic check(input string tag, input logic [N+M-1:0] exp);
        n_vec++;
        assert (Y === exp) else begin
            n_err++;
            $error("FAIL %s: Y=%0d expected %0d", tag, Y, exp);
        end
    endtask

    // Each step checks the product due now, then presents a new operand pair.
    task automatic step(input string tag, input logic [N-1:0] a, input logic [M-1:0] b);
        @(negedge clk);
        check(tag, exp_q.pop_front());
        A = a;
        B = b;
        exp_q.push_back(ref_mul(a, b));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (LAT - 1) exp_q.push_back('0);
        exp_q.push_back(ref_mul(A, B));
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_imm"}, '0);
        @(negedge clk);
        check({tag, "_hold"}, '0);
        @(posedge clk);
        #1;
        check({tag, "_edge"}, '0);
        release_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        A = 8'hFF;
        B = 8'hFF;
        repeat (2) @(negedge clk);
        check("reset_hold", '0);
        release_reset();

        step("rel_ff", 8'hFF, 8'hFF);
        step("rel_ff", 8'hFF, 8'hFF);
        step("rel_ff", 8'd255, 8'd255);
        step("dir", 8'd255, 8'd0);
        step("dir", 8'd0, 8'd0);
        step("dir", 8'd0, 8'd255);
        step("dir", 8'd13, 8'd11);
        step("dir", 8'd128, 8'd2);
        step("dir", 8'd1, 8'd200);
        step("dir", 8'd255, 8'd1);
        step("dir", 8'd1, 8'd255);
        step("stream", 8'd3, 8'd5);
        step("stream", 8'd100, 8'd100);
        step("stream", 8'd255, 8'd1);

        for (int i = 0; i < 64; i++) begin
            step("rnd", 8'($urandom), 8'($urandom));
        end

        for (int i = 0; i < 4; i++) begin
            step("pre_rst", 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        end
        async_reset("mid_rst");

        for (int i = 0; i < 12; i++) begin
            step("post_rst", 8'($urandom), 8'($urandom));
        end

        repeat (LAT + 1) step("drain", 8'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/array_mul_usign.md
Name: array_mul_usign

Overview:
- Parameterised unsigned N x M array multiplier built from an explicit grid of AND partial-product gates and full/half-adder cells.
- Inputs and the product are registered, so the block drops into a synchronous datapath as a fixed-latency arithmetic unit.
- Used wherever a small unsigned product is needed without relying on synthesis-inferred multipliers.

Parameters:
- N, 8, width of operand A in bits (N >= 2)
- M, 8, width of operand B in bits (M >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  N  unsigned multiplicand
- B  input  M  unsigned multiplier
- Y  output  N+M  unsigned product A*B, registered

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset: while rst_n=0, all internal registers and Y are 0. Reset takes effect immediately, independent of clk.
- Stage 0: A and B are captured into input registers a_q and b_q on every rising clk edge. There is no enable.
- Array: a combinational array operates on a_q and b_q.
  - Partial products: pp[j][i] = a_q[i] & b_q[j].
  - Row 0 is pp[0].
  - Rows 1..M-1 each add pp[j], shifted left by j, to the running sum using a ripple chain of N adder cells. Use half adders where one input is a constant 0.
  - The carry-out of each row feeds the MSB of the next row.
  - Final row carry-out forms bit N+M-1.
- Stage 1: the array result is registered into Y on the next rising clk edge.
- Latency: 2 clk cycles from A/B sampled to Y valid. Throughput is one new operand pair per cycle.
- Arithmetic:
  - Full-width, exact unsigned product. No truncation, no overflow possible.
  - Maximum result is (2^N-1)*(2^M-1), which fits in N+M bits.
- Operator rules:
  - Adder cells are separate instantiated full_adder/half_adder submodules or generate-loop cells.
  - The '*' operator is not permitted in the RTL.
- Boundary conditions:
  - Any operand 0 gives Y=0.
  - An all-ones operand with 1 gives the other operand.
  - Reset asserted mid-stream discards all in-flight products. After rst_n deasserts, Y is 0 until two rising edges have occurred.
- Inputs changing every cycle: each pair produces its own product, in order, with exactly 2-cycle latency.

Optional Feature:
- Macro: ARRAY_MUL_PIPE_EN.
- When defined:
  - An extra register stage is inserted after row floor(M/2) of the adder array. It holds the running partial sum, the carry, the unconsumed high bits of b_q and a copy of a_q.
  - Latency becomes 3 cycles. Throughput stays one pair per cycle.
  - The extra registers are also cleared by rst_n.
- When undefined: the array is purely combinational between the two stages, with 2-cycle latency.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- Reset: hold rst_n=0 with A=8'hFF, B=8'hFF -> Y=0. Release, then 2 edges later -> Y=65025.
- Worst case: A=255, B=255 -> Y=65025 (16'hFE01) after latency. A=255, B=0 -> Y=0. A=0, B=0 -> Y=0. A=0, B=255 -> Y=0.
- Directed values: A=13, B=11 -> Y=143. A=128, B=2 -> Y=256. A=1, B=200 -> Y=200.
- Back-to-back streaming: apply (3,5), (100,100), (255,1) on consecutive cycles. Y shows 15, 10000, 255 on consecutive cycles, starting 2 cycles after the first pair (3 cycles with ARRAY_MUL_PIPE_EN).
- Random: 50+ random pairs, with Y compared against a reference A*B after the build's latency. Any mismatch flags an error.
- Mid-stream reset: pulse rst_n low asynchronously between edges while products are in flight -> Y goes to 0 immediately, and no stale product appears after release.
